csr_shadow_bank: RTL
====================

CSR_SHADOW_BANK -- requirements
Module: csr_shadow_bank

Interface
REQ-001 Parameter REG_NUM, default 32, meaning total CSR word count (min 8).
REQ-002 Parameter ADDR_W, default 5, meaning request address width (clog2 REG_NUM).
REQ-003 Parameter NUM_OP, default 8, meaning number of launchable operations (start/done pairs).
REQ-004 One clock; reset is synchronous and active-high: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 csb2csr_req_vld  in  1  request valid.
REQ-006 csb2csr_req_rdy  out  1  request ready, tied 1.
REQ-007 csb2csr_req_pd  in  ADDR_W+33  {wr_rd, wdata[31:0], addr[ADDR_W-1:0]}, MSB=1 is write.
REQ-008 csr2csb_resp_vld  out  1  read response valid.
REQ-009 csr2csb_resp_pd  out  32  read data.
REQ-010 op_start  out  NUM_OP  one-cycle one-hot launch pulse.
REQ-011 op_done  in  NUM_OP  completion pulses from datapaths.
REQ-012 cfg_active  out  32*(REG_NUM-4)  active copy of config regs 4..REG_NUM-1, word k at bits [32k+31:32k].
REQ-013 irq  out  1  level interrupt = done_sticky & irq_en.

Function
REQ-014 Map: 0 CMD (W), 1 STATUS, 2 IRQ_EN (bit0), 3 PERF_CNT, 4..REG_NUM-1 config shadow.
REQ-015 Reads: csr2csb_resp_vld and csr2csb_resp_pd update exactly 1 cycle after an accepted read; unmapped/CMD addresses read 0; config addresses return shadow values.
REQ-016 STATUS read = {28'b0, error, pending, busy, done_sticky}; a write clears bit0 and/or bit3 where wdata has a 1 (W1C); bits 1-2 are read-only.
REQ-017 A config write updates only the shadow; cfg_active changes only at commit.
REQ-018 A CMD write with wdata[NUM_OP-1:0] not one-hot sets error and is otherwise ignored.
REQ-019 FSM states IDLE, LAUNCH, BUSY; busy = (state != IDLE).
REQ-020 IDLE + valid CMD: copy all shadows to cfg_active, latch op index, go LAUNCH next cycle.
REQ-021 LAUNCH: assert op_start for the latched op for exactly one cycle (one cycle after commit, so cfg_active is stable), then go BUSY.
REQ-022 BUSY: only op_done of the running op is accepted; other op_done bits are ignored.
REQ-023 On accepted done: set done_sticky; if pending, commit shadows, load the pending op, clear pending, go LAUNCH; otherwise go IDLE.
REQ-024 Valid CMD while LAUNCH/BUSY with pending empty: store the op in a one-deep pending slot; shadows are not committed until launch.
REQ-025 Valid CMD while pending full sets error; the CMD is dropped and the slot is unchanged.
REQ-026 Valid CMD in the same cycle as an accepted done with pending empty: the CMD launches directly as in REQ-023 and does not use the pending slot.
REQ-027 done_sticky set by done and W1C in the same cycle: set wins.
REQ-028 PERF_CNT increments by 1 each cycle in LAUNCH/BUSY and saturates at 0xFFFFFFFF; a write loads wdata and takes priority over the increment.

Reset
REQ-029 rst (sync, active-high) clears state to IDLE and zeroes all shadows, cfg_active, pending, error, done_sticky, irq_en, PERF_CNT, op_start, csr2csb_resp_vld and csr2csb_resp_pd.
REQ-030 Reset mid-BUSY abandons the operation; op_done is ignored until a new launch.

Structure
REQ-031 Shared package csr_pkg holds REG_CMD/REG_STATUS/REG_IRQ_EN/REG_PERF/REG_CFG0 indices, STATUS bit positions and the state enum.
REQ-032 One sub-module, csr_perf_counter (32-bit saturating counter with load), is instantiated once.

Verification
REQ-033 Write reg4=0x1234, CMD=0x04 -> cfg_active word0=0x1234 on cycle N+1 and op_start=0x04 on cycle N+2; STATUS reads 0x2.
REQ-034 BUSY op2, write reg4=0x55, CMD=0x08, then op_done=0x04 -> cfg_active word0=0x55 and op_start=0x08 follow; STATUS.pending returns to 0.
REQ-035 BUSY with pending full, CMD=0x01 -> STATUS=0xE; writing STATUS=0x8 clears error and leaves pending=1.
REQ-036 CMD=0x03 -> STATUS.error=1, no op_start, state IDLE.
REQ-037 IRQ_EN=1, op completes -> irq=1; W1C of done in the same cycle as a new done -> irq stays 1.
REQ-038 PERF_CNT loaded with 0xFFFFFFFE over a 5-cycle op -> reads 0xFFFFFFFF; rst asserted mid-BUSY -> all reads 0 and op_start stays 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared register map, STATUS bit positions and sequencer state encoding
// for the CSR shadow bank.
package csr_pkg;

    localparam int unsigned REG_CMD    = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_IRQ_EN = 2;
    localparam int unsigned REG_PERF   = 3;
    localparam int unsigned REG_CFG0   = 4;

    localparam int unsigned ST_DONE = 0;
    localparam int unsigned ST_BUSY = 1;
    localparam int unsigned ST_PEND = 2;
    localparam int unsigned ST_ERR  = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2
    } csr_state_e;

endpackage

// File: rtl/csr_perf_counter.sv
// 32-bit saturating cycle counter with a load that overrides the increment.
module csr_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/csr_shadow_bank.sv
// CSR bank with shadowed config registers committed to cfg_active at each
// operation launch, plus a one-deep pending command slot.
//
//   state    | meaning
//   S_IDLE   | no operation running, waiting for a valid CMD
//   S_LAUNCH | shadows just committed; op_start pulses on the next cycle
//   S_BUSY   | waiting for op_done of the running op
module csr_shadow_bank
    import csr_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_OP  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csb2csr_req_vld,
    output logic                      csb2csr_req_rdy,
    input  logic [ADDR_W+32:0]        csb2csr_req_pd,
    output logic                      csr2csb_resp_vld,
    output logic [31:0]               csr2csb_resp_pd,
    output logic [NUM_OP-1:0]         op_start,
    input  logic [NUM_OP-1:0]         op_done,
    output logic [32*(REG_NUM-4)-1:0] cfg_active,
    output logic                      irq
);

    localparam int NCFG = REG_NUM - 4;
    localparam int OPW  = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;

    logic              req_wr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       addr_u;

    csr_state_e        state;
    logic [31:0]       shadow [NCFG];
    logic [OPW-1:0]    cur_op, pend_op, cmd_idx;
    logic              pend_vld, error, done_sticky, irq_en, busy;
    logic [31:0]       perf_cnt, rd_data;
    logic              wr_acc, rd_acc, cmd_wr, cmd_ok, cmd_bad, done_acc;
    logic              perf_ld, commit, cmd_full, cmd_to_pend;

    assign req_wr = csb2csr_req_pd[ADDR_W+32];
    assign wdata  = csb2csr_req_pd[ADDR_W+31:ADDR_W];
    assign addr   = csb2csr_req_pd[ADDR_W-1:0];
    assign addr_u = 32'(addr);

    assign csb2csr_req_rdy = 1'b1;
    assign wr_acc   = csb2csr_req_vld & req_wr;
    assign rd_acc   = csb2csr_req_vld & ~req_wr;
    assign cmd_wr   = wr_acc && (addr_u == REG_CMD);
    assign cmd_ok   = cmd_wr && $onehot(wdata[NUM_OP-1:0]);
    assign cmd_bad  = cmd_wr && !$onehot(wdata[NUM_OP-1:0]);
    assign busy     = (state != S_IDLE);
    assign done_acc = (state == S_BUSY) && op_done[cur_op];
    assign perf_ld  = wr_acc && (addr_u == REG_PERF);
    assign irq      = done_sticky & irq_en;

    // A CMD arriving with the running op's done and an empty slot launches directly.
    assign commit      = ((state == S_IDLE) && cmd_ok) || (done_acc && (pend_vld || cmd_ok));
    assign cmd_full    = cmd_ok && busy && pend_vld;
    assign cmd_to_pend = cmd_ok && busy && !pend_vld && !done_acc;

    always_comb begin
        cmd_idx = '0;
        for (int i = 0; i < NUM_OP; i++) begin
            if (wdata[i]) cmd_idx = OPW'(i);
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_u == REG_STATUS) begin
            rd_data = {28'b0, error, pend_vld, busy, done_sticky};
        end else if (addr_u == REG_IRQ_EN) begin
            rd_data = {31'b0, irq_en};
        end else if (addr_u == REG_PERF) begin
            rd_data = perf_cnt;
        end else begin
            for (int k = 0; k < NCFG; k++) begin
                if (addr_u == (REG_CFG0 + k)) rd_data = shadow[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_op      <= '0;
            pend_op     <= '0;
            pend_vld    <= 1'b0;
            error       <= 1'b0;
            done_sticky <= 1'b0;
            op_start    <= '0;
        end else begin
            op_start <= '0;
            if (wr_acc && (addr_u == REG_STATUS)) begin
                if (wdata[ST_DONE]) done_sticky <= 1'b0;
                if (wdata[ST_ERR])  error       <= 1'b0;
            end
            if (cmd_bad || cmd_full) error <= 1'b1;
            if (cmd_to_pend) begin
                pend_vld <= 1'b1;
                pend_op  <= cmd_idx;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_ok) begin
                        cur_op <= cmd_idx;
                        state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    op_start <= NUM_OP'(1) << cur_op;
                    state    <= S_BUSY;
                end
                S_BUSY: begin
                    if (done_acc) begin
                        done_sticky <= 1'b1;
                        if (pend_vld) begin
                            cur_op   <= pend_op;
                            pend_vld <= 1'b0;
                            state    <= S_LAUNCH;
                        end else if (cmd_ok) begin
                            cur_op <= cmd_idx;
                            state  <= S_LAUNCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en           <= 1'b0;
            csr2csb_resp_vld <= 1'b0;
            csr2csb_resp_pd  <= '0;
            cfg_active       <= '0;
            for (int k = 0; k < NCFG; k++) shadow[k] <= '0;
        end else begin
            csr2csb_resp_vld <= rd_acc;
            if (rd_acc) csr2csb_resp_pd <= rd_data;
            if (wr_acc && (addr_u == REG_IRQ_EN)) irq_en <= wdata[0];
            for (int k = 0; k < NCFG; k++) begin
                if (wr_acc && (addr_u == (REG_CFG0 + k))) shadow[k] <= wdata;
                if (commit) cfg_active[32*k +: 32] <= shadow[k];
            end
        end
    end

    csr_perf_counter u_perf (
        .clk      (clk),
        .rst      (rst),
        .load     (perf_ld),
        .load_val (wdata),
        .inc      (busy),
        .count    (perf_cnt)
    );

endmodule
